// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: state encoding and default operand width.
package serial_sub_pkg;

  localparam int SUB_WIDTH = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    SHIFT = S_SHIFT,
    DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, shared with the ripple-carry adder.
// Purely combinational; no latency, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial d = s - b - bin via s + ~b + ~bin, one bit per clock; result after WIDTH+1 edges.
// Result and out_valid hold in DONE until out_ready; no new operand is taken until then.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = SUB_WIDTH,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s_sr, nb_sr, res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  full_adder u_fa (
    .a    (s_sr[0]),
    .b    (nb_sr[0]),
    .cin  (carry),
    .s    (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtrahend is stored inverted and carry seeded with ~bin, so the adder cell performs the subtraction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sr   <= '0;
      nb_sr  <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_sr  <= s;
            nb_sr <= ~b;
            carry <= ~bin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          s_sr   <= s_sr >> 1;
          nb_sr  <= nb_sr >> 1;
          res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated so they read as zero outside DONE, matching their reset values.
  assign d    = (state == DONE) ? res_sr : '0;
  assign bout = (state == DONE) & ~carry;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and sweep bench for serial_subtractor at WIDTH=4 and WIDTH=8, scoreboard-checked.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid4 = 1'b0, in_ready4, bin4 = 1'b0, out_valid4, out_ready4 = 1'b1, bout4;
  logic [3:0] s4 = '0, b4 = '0, d4;
  logic       in_valid8 = 1'b0, in_ready8, bin8 = 1'b0, out_valid8, out_ready8 = 1'b1, bout8;
  logic [7:0] s8 = '0, b8 = '0, d8;

  exp_t q4[$];
  exp_t q8[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .s(s4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .d(d4), .bout(bout4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .s(s8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .d(d8), .bout(bout8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [7:0] sv, input logic [7:0] bv, input logic binv);
    exp_t e;
    int   diff;
    diff   = int'(sv) - int'(bv) - int'(binv);
    e.d    = 8'(diff & ((1 << w) - 1));
    e.bout = (int'(sv) < int'(bv) + int'(binv));
    return e;
  endfunction

  function automatic logic ov(input int w);
    return (w == 4) ? out_valid4 : out_valid8;
  endfunction
  function automatic logic ir(input int w);
    return (w == 4) ? in_ready4 : in_ready8;
  endfunction
  function automatic logic [7:0] dd(input int w);
    return (w == 4) ? {4'h0, d4} : d8;
  endfunction
  function automatic logic bo(input int w);
    return (w == 4) ? bout4 : bout8;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [7:0] sv, input logic [7:0] bv, input logic binv);
    if (w == 4) begin in_valid4 = v; s4 = sv[3:0]; b4 = bv[3:0]; bin4 = binv; end
    else        begin in_valid8 = v; s8 = sv;      b8 = bv;      bin8 = binv; end
  endtask

  task automatic set_ordy(input int w, input logic v);
    if (w == 4) out_ready4 = v;
    else        out_ready8 = v;
  endtask

  // One operation: push expectation at drive time, pop and compare when out_valid appears.
  // hold > 0 keeps out_ready low that many cycles while pulsing in_valid with junk.
  task automatic run_op(input int w, input logic [7:0] sv, input logic [7:0] bv, input logic binv, input int hold);
    exp_t       e;
    int         lat;
    logic [7:0] mask;
    mask = 8'((1 << w) - 1);
    @(negedge clk);
    check("in_ready_idle", 32'(ir(w)), 32'd1);
    set_in(w, 1'b1, sv, bv, binv);
    set_ordy(w, hold == 0);
    if (w == 4) q4.push_back(model(w, sv, bv, binv));
    else        q8.push_back(model(w, sv, bv, binv));
    @(posedge clk);
    #1;
    set_in(w, 1'b0, ~sv, ~bv, ~binv);
    lat = 1;
    while (!ov(w) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid", 32'(ov(w)), 32'd1);
    check("latency", lat, w + 1);
    e.d = '0; e.bout = 1'b0;
    check("sb_nonempty", 32'((w == 4) ? q4.size() : q8.size()), 32'd1);
    if (w == 4 && q4.size() > 0) e = q4.pop_front();
    if (w == 8 && q8.size() > 0) e = q8.pop_front();
    check("d", 32'(dd(w)), 32'(e.d));
    check("bout", 32'(bo(w)), 32'(e.bout));
    check("adder_roundtrip", 32'((dd(w) + bv + 8'(binv)) & mask), 32'(sv & mask));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        set_in(w, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        check("bp_out_valid", 32'(ov(w)), 32'd1);
        check("bp_d", 32'(dd(w)), 32'(e.d));
        check("bp_bout", 32'(bo(w)), 32'(e.bout));
        check("bp_in_ready", 32'(ir(w)), 32'd0);
      end
      @(negedge clk);
      set_in(w, 1'b0, sv, bv, binv);
      check("bp_final_d", 32'(dd(w)), 32'(e.d));
      set_ordy(w, 1'b1);
    end
    @(posedge clk);
    #1;
    check("out_valid_drop", 32'(ov(w)), 32'd0);
    check("in_ready_back", 32'(ir(w)), 32'd1);
  endtask

  initial begin
    #2;
    check("rst_in_ready4", 32'(in_ready4), 32'd1);
    check("rst_out_valid4", 32'(out_valid4), 32'd0);
    check("rst_d4", 32'(d4), 32'd0);
    check("rst_bout4", 32'(bout4), 32'd0);
    check("rst_out_valid8", 32'(out_valid8), 32'd0);
    #5;
    rst = 1'b0;

    run_op(4, 8'h7, 8'h4, 1'b0, 0);
    run_op(4, 8'h5, 8'he, 1'b0, 0);
    run_op(4, 8'h2, 8'h8, 1'b1, 0);
    run_op(4, 8'ha, 8'hf, 1'b1, 0);
    run_op(4, 8'hf, 8'h1, 1'b0, 0);
    run_op(4, 8'h6, 8'h6, 1'b0, 0);
    run_op(4, 8'h0, 8'h1, 1'b1, 0);

    run_op(4, 8'h9, 8'h3, 1'b1, 5);
    @(posedge clk);
    #1;
    check("bp_no_extra", 32'(out_valid4), 32'd0);

    // Reset asserted during the second SHIFT cycle must abort without emitting a result.
    @(negedge clk);
    set_in(4, 1'b1, 8'h3, 8'h1, 1'b0);
    @(posedge clk);
    #1;
    set_in(4, 1'b0, 8'h0, 8'h0, 1'b0);
    @(posedge clk);
    #1;
    check("mid_in_ready_busy", 32'(in_ready4), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready4), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid4), 32'd0);
    check("mid_rst_d", 32'(d4), 32'd0);
    check("mid_rst_bout", 32'(bout4), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(4, 8'h0, 8'hf, 1'b1, 0);

    for (int si = 0; si < 16; si++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          run_op(4, 8'(si), 8'(bi), 1'(ci), 0);

    run_op(8, 8'h00, 8'hff, 1'b1, 0);
    run_op(8, 8'h80, 8'h80, 1'b0, 0);
    run_op(8, 8'hff, 8'h00, 1'b0, 3);
    for (int i = 0; i < 150; i++)
      run_op(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);

    check("sb4_drained", 32'(q4.size()), 32'd0);
    check("sb8_drained", 32'(q8.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
